// File: rtl/ptos_param_serializer.sv
// Parallel-to-serial lane transmitter: one bit per clk, comma preamble after reset,
// comma fill when idle and a one-word holding buffer behind the shift register.
//   state | meaning
//   SYNC  | sending the post-reset comma preamble, upstream held off
//   RUN   | preamble complete, data words accepted and transmitted
module ptos_param_serializer #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter bit               MSB_FIRST  = 1'b1,
  parameter int unsigned      SYNC_WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_serial,
  output logic             out_word_start,
  output logic             out_is_comma,
  output logic             sync_done
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
  localparam logic [BCW-1:0] LAST      = BCW'(WIDTH - 1);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_WORDS - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             word_is_comma;
  logic [BCW-1:0]   bit_cnt;
  logic [SCW-1:0]   sync_cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit       = (bit_cnt == LAST);
  assign sync_done      = (state == RUN);
  assign in_ready       = sync_done & (~hold_valid | last_bit);
  assign accept         = in_valid & in_ready;
  assign out_serial     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign out_word_start = (bit_cnt == '0);
  assign out_is_comma   = word_is_comma;

  always_comb begin
    shreg_shifted = shreg;
    if (MSB_FIRST) shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    else           shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SYNC;
      shreg         <= COMMA;
      hold          <= '0;
      hold_valid    <= 1'b0;
      word_is_comma <= 1'b1;
      bit_cnt       <= '0;
      sync_cnt      <= '0;
    end else if (!last_bit) begin
      shreg   <= shreg_shifted;
      bit_cnt <= bit_cnt + BCW'(1);
      if (accept) begin
        hold       <= in;
        hold_valid <= 1'b1;
      end
    end else begin
      bit_cnt <= '0;
      // hold is older than the word offered now, so it goes out first
      if (hold_valid) begin
        shreg         <= hold;
        word_is_comma <= 1'b0;
        if (accept) hold <= in;
        else        hold_valid <= 1'b0;
      end else if (accept) begin
        shreg         <= in;
        word_is_comma <= 1'b0;
      end else begin
        shreg         <= COMMA;
        word_is_comma <= 1'b1;
      end
      if (state == SYNC) begin
        if (sync_cnt == SYNC_LAST) state <= RUN;
        else                       sync_cnt <= sync_cnt + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ptos_param_serializer.sv
// Scoreboard bench: accepted words queue up in order; the monitor expects each word
// slot after the preamble to carry the oldest pending word, or COMMA when none is pending.
module tb_ptos_param_serializer;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam logic [7:0] CM = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_d = 8'h00;
  logic       in_valid = 1'b0;
  logic       rdy0, ser0, ws0, ic0, sd0;
  logic       rdy1, ser1, ws1, ic1, sd1;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         pos[2];
  int         nword[2];
  logic [7:0] cur[2];
  logic       cur_c[2];

  always #5 clk = ~clk;

  ptos_param_serializer #(.WIDTH(8), .COMMA(8'hBC), .MSB_FIRST(1'b1), .SYNC_WORDS(4)) dut_msb (
    .clk(clk), .reset(reset), .in(in_d), .in_valid(in_valid), .in_ready(rdy0),
    .out_serial(ser0), .out_word_start(ws0), .out_is_comma(ic0), .sync_done(sd0));

  ptos_param_serializer #(.WIDTH(8), .COMMA(8'hBC), .MSB_FIRST(1'b0), .SYNC_WORDS(4)) dut_lsb (
    .clk(clk), .reset(reset), .in(in_d), .in_valid(in_valid), .in_ready(rdy1),
    .out_serial(ser1), .out_word_start(ws1), .out_is_comma(ic1), .sync_done(sd1));

  // Advance the reference for one cycle of instance id and compare its outputs.
  task automatic model_cycle(input int id, input logic ser, input logic ws, input logic ic,
                             input logic sd, input logic rdy);
    logic [7:0] w;
    logic       have;
    logic       bit_e, sd_e, rdy_e;
    logic [4:0] got, exp;
    int         qs;
    w = CM;
    have = 1'b0;
    if (reset) begin
      pos[id] = 0;
      nword[id] = 0;
      cur[id] = CM;
      cur_c[id] = 1'b1;
      if (id == 0) q0.delete(); else q1.delete();
    end else begin
      pos[id]++;
      if (pos[id] == W) begin
        pos[id] = 0;
        if (nword[id] < SW) nword[id]++;
        if (nword[id] >= SW) begin
          if (id == 0 && q0.size() > 0) begin w = q0.pop_front(); have = 1'b1; end
          else if (id == 1 && q1.size() > 0) begin w = q1.pop_front(); have = 1'b1; end
        end
        cur[id] = have ? w : CM;
        cur_c[id] = ~have;
      end
    end
    qs = (id == 0) ? q0.size() : q1.size();
    bit_e = (id == 0) ? cur[id][W-1-pos[id]] : cur[id][pos[id]];
    sd_e  = (nword[id] >= SW);
    rdy_e = sd_e && (qs == 0 || pos[id] == W - 1);
    exp = {bit_e, (pos[id] == 0), cur_c[id], sd_e, rdy_e};
    got = {ser, ws, ic, sd, rdy};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL outputs inst=%0d t=%0t {serial,word_start,is_comma,sync_done,in_ready} got=%b exp=%b",
               id, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_cycle(0, ser0, ws0, ic0, sd0, rdy0);
      model_cycle(1, ser1, ws1, ic1, sd1, rdy1);
    end
  end

  // Drive for the coming edge; in_ready is register-decoded so it is already settled.
  task automatic drive(input logic v, input logic [7:0] d, output logic acc);
    in_valid = v;
    in_d = d;
    acc = v && rdy0 && !reset;
    if (acc) q0.push_back(d);
    if (v && rdy1 && !reset) q1.push_back(d);
  endtask

  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    @(negedge clk);
    drive(v, d, acc);
  endtask

  task automatic idle(input int n, input logic [7:0] d);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, d, acc);
  endtask

  task automatic send_word(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) step(1'b1, d, acc);
    compared++;
    if (!acc) begin
      mismatched++;
      $display("FAIL accept_timeout data=%h got=not_accepted exp=accepted within 64 cycles", d);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic acc;
    logic found;
    logic v;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // preamble with nothing offered, then a single word
    idle(32, 8'hCC);
    send_word(8'hAA);
    idle(12, 8'hCC);

    for (int k = 0; k < 5; k++) send_word(8'hEE);
    idle(20, 8'hCC);

    send_word(8'hEE);
    idle(16, 8'hCC);
    send_word(8'hBB);
    send_word(CM);
    idle(24, 8'hCC);

    // reset while the holding buffer is full, three bits into a word
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (pos[0] == 3 && q0.size() == 1) begin
        found = 1'b1;
        reset = 1'b1;
        in_valid = 1'b0;
      end else begin
        drive(1'b1, 8'h5A, acc);
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL hold_full_mid_word got=not_reached exp=reached within 200 cycles");
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    idle(48, 8'hCC);

    // random traffic with one reset in the middle
    for (int k = 0; k < 1600; k++) begin
      if (k == 777) begin
        pulse_reset(2);
      end else begin
        v = ($urandom_range(0, 99) < 60);
        d = ($urandom_range(0, 7) == 0) ? CM : 8'($urandom);
        step(v, d, acc);
      end
    end

    idle(40, 8'hCC);
    compared++;
    if (q0.size() != 0) begin
      mismatched++;
      $display("FAIL drain_msb pending got=%0d exp=0", q0.size());
    end
    compared++;
    if (q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain_lsb pending got=%0d exp=0", q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
